seg7_scan_mux: RTL and testbench

- Downstream stage for the 8-bit Johnson counter's two 7-segment digit codes (HEX0, HEX1).
- Time-multiplexes both digits onto one shared segment bus with active-low digit enables, for boards with a scanned display.
- Inserts a blanking gap between digits to suppress ghosting.
- Latches the inputs once per frame so a digit pair never tears mid-frame.

---
 rtl/seg7_scan_pkg.sv | 21 ++
 rtl/seg7_scan_mux_if.sv | 38 +++
 rtl/seg7_scan_timer.sv | 32 +++
 rtl/seg7_scan_mux.sv | 130 +++++++++++++
 tb/tb_seg7_scan_mux.sv | 157 +++++++++++++++
 5 files changed

// File: rtl/seg7_scan_pkg.sv
// Shared types and constants for the two-digit scanned 7-segment driver.
package seg7_scan_pkg;

    typedef enum logic [1:0] {
        SHOW0  = 2'd0,
        BLANK0 = 2'd1,
        SHOW1  = 2'd2,
        BLANK1 = 2'd3
    } state_e;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [1:0] AN_OFF    = 2'b11;
    localparam logic [1:0] AN_D0     = 2'b10;
    localparam logic [1:0] AN_D1     = 2'b01;

    // Number of lit cycles at the start of a SHOW state for a given brightness.
    function automatic logic [31:0] dim_limit(input logic [1:0] bright, input logic [31:0] div);
        return ((32'(bright) + 32'd1) * div) >> 2;
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Digit inputs and scanned display outputs of seg7_scan_mux; BRIGHT exists only
// when SEG7_SCAN_DIM_EN is defined.
interface seg7_scan_mux_if;
    import seg7_scan_pkg::*;

    // No handshake: inputs are level-sampled every clock, outputs are registered
    // and valid on every cycle.
    logic       en;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [6:0] SEG;
    logic [1:0] AN;
    logic       FRAME_TICK;
    state_e     dbg_state;

`ifdef SEG7_SCAN_DIM_EN
    logic [1:0] BRIGHT;

    modport master (
        output en, HEX0, HEX1, BRIGHT,
        input  SEG, AN, FRAME_TICK, dbg_state
    );
    modport slave (
        input  en, HEX0, HEX1, BRIGHT,
        output SEG, AN, FRAME_TICK, dbg_state
    );
`else
    modport master (
        output en, HEX0, HEX1,
        input  SEG, AN, FRAME_TICK, dbg_state
    );
    modport slave (
        input  en, HEX0, HEX1,
        output SEG, AN, FRAME_TICK, dbg_state
    );
`endif

endinterface

// File: rtl/seg7_scan_timer.sv
// Per-state cycle counter: counts up from zero and flags the terminal count;
// cleared whenever the owner changes state.
module seg7_scan_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear_i,
    input  logic [CNT_W-1:0] limit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             done_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = clear_i ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == limit_i);

endmodule

// File: rtl/seg7_scan_mux.sv
// Scans two 7-segment digits onto one bus with blanking gaps and per-frame input
// capture. Define SEG7_SCAN_DIM_EN to add the BRIGHT duty-cycle dimming input.
module seg7_scan_mux
    import seg7_scan_pkg::*;
#(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic            clk,
    input  logic            reset,
    seg7_scan_mux_if.slave  bus
);

    localparam int CNT_MAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] LIM_SHOW  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] LIM_BLANK = CNT_W'(BLANK_CYCLES - 1);

    state_e           state_q;
    logic [6:0]       shadow0_q;
    logic [6:0]       shadow1_q;
    logic [6:0]       seg_q;
    logic [1:0]       an_q;
    logic             tick_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] limit;
    logic             done;
    logic             clear;
    logic             lit;
    logic [31:0]      duty_lim;
`ifdef SEG7_SCAN_DIM_EN
    logic [1:0]       bright_q;
`endif

    always_comb begin
        limit = (state_q == SHOW0 || state_q == SHOW1) ? LIM_SHOW : LIM_BLANK;
    end

    // Disable forces the counter back to zero so BLANK1 restarts a full gap.
    assign clear = !bus.en || done;

    // Lit decision looks at the count the next cycle will carry; full duty
    // makes the compare always true while staying in a SHOW state.
    always_comb begin
`ifdef SEG7_SCAN_DIM_EN
        duty_lim = dim_limit(bright_q, 32'(REFRESH_DIV));
`else
        duty_lim = 32'(REFRESH_DIV);
`endif
        lit = ((32'(cnt) + 32'd1) < duty_lim);
    end

    seg7_scan_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear_i (clear),
        .limit_i (limit),
        .cnt_o   (cnt),
        .done_o  (done)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= BLANK1;
            shadow0_q <= SEG_BLANK;
            shadow1_q <= SEG_BLANK;
            seg_q     <= SEG_BLANK;
            an_q      <= AN_OFF;
            tick_q    <= 1'b0;
`ifdef SEG7_SCAN_DIM_EN
            bright_q  <= 2'd3;
`endif
        end else begin
            tick_q <= 1'b0;
            seg_q  <= SEG_BLANK;
            an_q   <= AN_OFF;
            if (!bus.en) begin
                state_q <= BLANK1;
            end else begin
                unique case (state_q)
                    SHOW0: begin
                        if (done) begin
                            state_q <= BLANK0;
                        end else if (lit) begin
                            seg_q <= shadow0_q;
                            an_q  <= AN_D0;
                        end
                    end
                    BLANK0: begin
                        if (done) begin
                            state_q <= SHOW1;
                            seg_q   <= shadow1_q;
                            an_q    <= AN_D1;
                        end
                    end
                    SHOW1: begin
                        if (done) begin
                            state_q <= BLANK1;
                        end else if (lit) begin
                            seg_q <= shadow1_q;
                            an_q  <= AN_D1;
                        end
                    end
                    BLANK1: begin
                        if (done) begin
                            state_q   <= SHOW0;
                            shadow0_q <= bus.HEX0;
                            shadow1_q <= bus.HEX1;
`ifdef SEG7_SCAN_DIM_EN
                            bright_q  <= bus.BRIGHT;
`endif
                            seg_q     <= bus.HEX0;
                            an_q      <= AN_D0;
                            tick_q    <= 1'b1;
                        end
                    end
                    default: state_q <= BLANK1;
                endcase
            end
        end
    end

    assign bus.SEG        = seg_q;
    assign bus.AN         = an_q;
    assign bus.FRAME_TICK = tick_q;
    assign bus.dbg_state  = state_q;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboarded bench for seg7_scan_mux with REFRESH_DIV=8, BLANK_CYCLES=2.
module tb_seg7_scan_mux;
    import seg7_scan_pkg::*;

    localparam int RD = 8;
    localparam int BC = 2;
    localparam int FRAME = 2 * (RD + BC);

    // clock / reset
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    seg7_scan_mux_if bus ();

    seg7_scan_mux #(
        .REFRESH_DIV  (RD),
        .BLANK_CYCLES (BC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // scoreboard: {AN, SEG, FRAME_TICK} expected per cycle
    logic [9:0] exp_q[$];
    logic [9:0] mon_e;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check_val("scan", {22'd0, bus.AN, bus.SEG, bus.FRAME_TICK}, {22'd0, mon_e});
        end
    end

    // driver tasks
    task automatic push_cycle(input logic [1:0] an, input logic [6:0] seg, input logic ft);
        @(posedge clk);
        #1;
        exp_q.push_back({an, seg, ft});
    endtask

    task automatic exp_blank(input int n);
        for (int i = 0; i < n; i++) push_cycle(AN_OFF, SEG_BLANK, 1'b0);
    endtask

    // One frame from its first SHOW0 cycle; lit = lit cycles per digit.
    task automatic run_frame(input logic [6:0] s0, input logic [6:0] s1, input int lit,
                             input int last_p, input int chg_at,
                             input logic [6:0] n0, input logic [6:0] n1);
        for (int p = 0; p <= last_p; p++) begin
            if (p < RD) begin
                if (p < lit) push_cycle(AN_D0, s0, p == 0);
                else         push_cycle(AN_OFF, SEG_BLANK, 1'b0);
            end else if (p < RD + BC) begin
                push_cycle(AN_OFF, SEG_BLANK, 1'b0);
            end else if (p < 2 * RD + BC) begin
                if (p - (RD + BC) < lit) push_cycle(AN_D1, s1, 1'b0);
                else                     push_cycle(AN_OFF, SEG_BLANK, 1'b0);
            end else begin
                push_cycle(AN_OFF, SEG_BLANK, 1'b0);
            end
            if (p == chg_at) begin
                bus.HEX0 = n0;
                bus.HEX1 = n1;
            end
        end
    endtask

    task automatic check_blank_now(input string tag);
        check_val({tag, "_seg"}, {25'd0, bus.SEG}, {25'd0, SEG_BLANK});
        check_val({tag, "_an"}, {30'd0, bus.AN}, {30'd0, AN_OFF});
        check_val({tag, "_tick"}, {31'd0, bus.FRAME_TICK}, 32'd0);
    endtask

    initial begin
        reset    = 1'b0;
        bus.en   = 1'b1;
        bus.HEX0 = 7'h40;
        bus.HEX1 = 7'h79;
`ifdef SEG7_SCAN_DIM_EN
        bus.BRIGHT = 2'd3;
`endif
        // reset held for three cycles
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_blank_now("rst");
        end
        reset = 1'b1;
        exp_blank(BC - 1);
        run_frame(7'h40, 7'h79, RD, FRAME - 1, -1, 7'h40, 7'h79);
        run_frame(7'h40, 7'h79, RD, FRAME - 1, -1, 7'h40, 7'h79);

        // tear-free: HEX0 changes in SHOW1, then HEX1 changes in SHOW0
        run_frame(7'h40, 7'h79, RD, FRAME - 1, RD + BC + 2, 7'h24, 7'h79);
        run_frame(7'h24, 7'h79, RD, FRAME - 1, 3, 7'h24, 7'h30);
        run_frame(7'h24, 7'h30, RD, FRAME - 1, -1, 7'h24, 7'h30);

        // enable dropped at SHOW0 cycle 3
        run_frame(7'h24, 7'h30, RD, 3, -1, 7'h24, 7'h30);
        bus.en = 1'b0;
        exp_blank(5);
        bus.en = 1'b1;
        exp_blank(BC - 1);
        run_frame(7'h24, 7'h30, RD, FRAME - 1, -1, 7'h24, 7'h30);

        // enable dropped on the cycle BLANK1 would exit
        bus.en = 1'b0;
        exp_blank(3);
        bus.en = 1'b1;
        exp_blank(BC - 1);
        run_frame(7'h24, 7'h30, RD, FRAME - 1, -1, 7'h24, 7'h30);

`ifdef SEG7_SCAN_DIM_EN
        bus.BRIGHT = 2'd1;
        run_frame(7'h24, 7'h30, 4, FRAME - 1, -1, 7'h24, 7'h30);
        bus.BRIGHT = 2'd0;
        run_frame(7'h24, 7'h30, 2, FRAME - 1, -1, 7'h24, 7'h30);
        bus.BRIGHT = 2'd3;
        run_frame(7'h24, 7'h30, RD, FRAME - 1, -1, 7'h24, 7'h30);
`endif

        // asynchronous reset in the middle of SHOW1
        run_frame(7'h24, 7'h30, RD, RD + BC + 2, -1, 7'h24, 7'h30);
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_blank_now("arst");
        @(posedge clk);
        @(posedge clk);
        #1;
        check_blank_now("arst_hold");
        bus.HEX0 = 7'h12;
        reset = 1'b1;
        exp_blank(BC - 1);
        run_frame(7'h12, 7'h30, RD, FRAME - 1, -1, 7'h12, 7'h30);

        @(negedge clk);
        #1;
        check_val("drain", exp_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
